// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - RV32I data-memory responder with wait states and lane handling
//
// Purpose: serves single load/store requests against a word array of
// 2**(DM_ADDRESS-2) 32-bit words. Each accepted request waits LATENCY cycles.
// It then performs one access and holds the response until the consumer takes it.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-low
//   req_*      - request channel (valid/ready): we, byte addr, right-aligned wdata, funct3
//   rsp_*      - response channel (valid/ready): extended load data, error flag
//
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses raise
// rsp_err instead of being silently aligned down.

module dmem_responder #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int         WORDS  = 1 << (DM_ADDRESS - 2);

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [2:0]            r_funct3;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;
  logic [DATA_W-1:0]     r_mem [0:WORDS-1];

  logic [DM_ADDRESS-3:0] w_idx;
  logic                  w_bad_f3;
  logic                  w_mis;
  logic                  w_err;
  logic                  w_is_half;
  logic                  w_is_word;
  logic [1:0]            w_off;
  logic [3:0]            w_be;
  logic [DATA_W-1:0]     w_wdata_sh;
  logic [DATA_W-1:0]     w_word;
  logic [DATA_W-1:0]     w_sh;
  logic [DATA_W-1:0]     w_load;
  logic [DATA_W-1:0]     w_rdata;
  logic                  w_access;
  logic                  w_wr;

  assign w_idx     = r_addr[DM_ADDRESS-1:2];
  assign w_is_half = (r_funct3[1:0] == 2'b01);
  assign w_is_word = (r_funct3[1:0] == 2'b10);

  always_comb begin
    w_bad_f3 = 1'b0;
    if (r_we) begin
      w_bad_f3 = (r_funct3 > 3'b010);
    end else begin
      w_bad_f3 = (r_funct3 == 3'b011) || (r_funct3 == 3'b110) || (r_funct3 == 3'b111);
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis = (w_is_half && r_addr[0]) || (w_is_word && (r_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  assign w_err = w_bad_f3 || w_mis;

  // Without the trap, misaligned accesses are aligned down to their natural size.
  always_comb begin
    w_off = r_addr[1:0];
    if (w_is_word) begin
      w_off = 2'b00;
    end else if (w_is_half) begin
      w_off = {r_addr[1], 1'b0};
    end
  end

  always_comb begin
    w_be = 4'b1111;
    case (r_funct3[1:0])
      2'b00:   w_be = 4'b0001 << w_off;
      2'b01:   w_be = 4'b0011 << w_off;
      default: w_be = 4'b1111;
    endcase
  end

  assign w_wdata_sh = r_wdata << {w_off, 3'b000};
  assign w_word     = r_mem[w_idx];
  assign w_sh       = w_word >> {w_off, 3'b000};

  always_comb begin
    w_load = '0;
    case (r_funct3)
      3'b000:  w_load = {{(DATA_W-8){w_sh[7]}}, w_sh[7:0]};
      3'b001:  w_load = {{(DATA_W-16){w_sh[15]}}, w_sh[15:0]};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {{(DATA_W-8){1'b0}}, w_sh[7:0]};
      3'b101:  w_load = {{(DATA_W-16){1'b0}}, w_sh[15:0]};
      default: w_load = '0;
    endcase
  end

  assign w_rdata  = (r_we || w_err) ? '0 : w_load;
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
  // Reset sampled on the access edge wins: the store is abandoned.
  assign w_wr     = w_access && reset && r_we && !w_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= 3'b000;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
            r_cnt    <= 4'(LATENCY);
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_rdata <= w_rdata;
            r_err   <= w_err;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder

module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Reference memory as a little-endian byte array.
  logic [7:0] mdl [0:511];

  function automatic void model(input bit we, input logic [8:0] a, input logic [31:0] wd,
                                input logic [2:0] f3, output logic [31:0] rd, output bit er);
    int size;
    int ea;
    logic [31:0] v;
    bit legal;
    rd = 32'd0;
    er = 1'b0;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) begin
      er = 1'b1;
      return;
    end
    size = 1 << f3[1:0];
    ea = int'(a) - (int'(a) % size);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (ea != int'(a)) begin
      er = 1'b1;
      return;
    end
`endif
    if (we) begin
      for (int k = 0; k < size; k++) mdl[ea+k] = 8'(wd >> (8*k));
    end else begin
      v = 32'd0;
      for (int k = 0; k < size; k++) v = v | (32'(mdl[ea+k]) << (8*k));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
      rd = v;
    end
  endfunction

  task automatic start_req(input bit we, input logic [8:0] a, input logic [31:0] wd, input logic [2:0] f3);
    req_we = we;
    req_addr = a;
    req_wdata = wd;
    req_funct3 = f3;
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        return;
      end
    end
    chk("req_accept_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  // Returns at the negedge where rsp_valid is first seen; cyc = edges after handshake.
  task automatic wait_rsp(output int cyc);
    cyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        cyc = i;
        return;
      end
    end
    chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input bit we, input logic [8:0] a, input logic [31:0] wd, input logic [2:0] f3,
                        input int hold, output logic [31:0] rd, output bit er, output int cyc);
    bit stable;
    rsp_ready = (hold == 0);
    start_req(we, a, wd, f3);
    wait_rsp(cyc);
    rd = rsp_rdata;
    er = rsp_err;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (!(rsp_valid && rsp_rdata == rd && rsp_err == er && !req_ready)) stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] rd;
    logic [31:0] mrd;
    bit er;
    bit mer;
    int cyc;
    bit seen;

    vecs[0]  = '{1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 9'h010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 9'h011, 32'h00000080, 3'b000, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 9'h010, 32'h0,        3'b010, 32'hDEAD80EF, 1'b0};
    vecs[4]  = '{1'b0, 9'h011, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0};
    vecs[5]  = '{1'b0, 9'h011, 32'h0,        3'b100, 32'h00000080, 1'b0};
    vecs[6]  = '{1'b0, 9'h012, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0};
    vecs[7]  = '{1'b0, 9'h012, 32'h0,        3'b101, 32'h0000DEAD, 1'b0};
    vecs[8]  = '{1'b1, 9'h020, 32'hCAFEF00D, 3'b010, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 9'h020, 32'h11111111, 3'b100, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 9'h020, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0};
    vecs[11] = '{1'b0, 9'h020, 32'h0,        3'b011, 32'h0,        1'b1};
    vecs[12] = '{1'b1, 9'h022, 32'hABCD1234, 3'b001, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 9'h020, 32'h0,        3'b010, 32'h1234F00D, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs[14] = '{1'b0, 9'h012, 32'h0,        3'b010, 32'h0,        1'b1};
    vecs[15] = '{1'b0, 9'h013, 32'h0,        3'b001, 32'h0,        1'b1};
`else
    vecs[14] = '{1'b0, 9'h012, 32'h0,        3'b010, 32'hDEAD80EF, 1'b0};
    vecs[15] = '{1'b0, 9'h013, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0};
`endif

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Directed vectors
    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, 0, rd, er, cyc);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(cyc), 32'(LAT + 1));
    end

    // Backpressure with a pending request behind the held response
    rsp_ready = 1'b0;
    start_req(1'b0, 9'h010, 32'h0, 3'b010);
    wait_rsp(cyc);
    rd = rsp_rdata;
    chk("bp_rdata", rd, 32'hDEAD80EF);
    req_we = 1'b0;
    req_addr = 9'h011;
    req_funct3 = 3'b100;
    req_valid = 1'b1;
    seen = 1'b1;
    for (int h = 0; h < 5; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (!(rsp_valid && rsp_rdata == rd && !req_ready)) seen = 1'b0;
    end
    chk("bp_stable", 32'(seen), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_released_valid", 32'(rsp_valid), 32'd0);
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_pending_taken", 32'(req_ready), 32'd0);
    wait_rsp(cyc);
    chk("bp_pending_rdata", rsp_rdata, 32'h00000080);
    @(posedge clk);
    #1;

    // Reset while a store waits
    do_req(1'b1, 9'h030, 32'h0BADF00D, 3'b010, 0, rd, er, cyc);
    start_req(1'b1, 9'h030, 32'h12345678, 3'b010);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("rst_drop_valid", 32'(seen), 32'd0);
    chk("rst_drop_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 9'h030, 32'h0, 3'b010, 0, rd, er, cyc);
    chk("rst_drop_nowrite", rd, 32'h0BADF00D);

    // Fill the whole array so the model knows every byte
    for (int w = 0; w < 128; w++) begin
      logic [31:0] d;
      d = $urandom;
      model(1'b1, 9'(w * 4), d, 3'b010, mrd, mer);
      do_req(1'b1, 9'(w * 4), d, 3'b010, 0, rd, er, cyc);
    end

    // Random traffic against the model
    for (int i = 0; i < 150; i++) begin
      bit          we;
      logic [8:0]  a;
      logic [31:0] wd;
      logic [2:0]  f3;
      int          hold;
      we   = 1'($urandom);
      a    = 9'($urandom);
      wd   = $urandom;
      f3   = 3'($urandom);
      hold = $urandom_range(0, 2);
      model(we, a, wd, f3, mrd, mer);
      do_req(we, a, wd, f3, hold, rd, er, cyc);
      chk($sformatf("rnd%0d_rdata", i), rd, mrd);
      chk($sformatf("rnd%0d_err", i), 32'(er), 32'(mer));
      chk($sformatf("rnd%0d_latency", i), 32'(cyc), 32'(LAT + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
